// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: ALU function codes,
// sequencer FSM states and the packed command record size.
package alu_op_sequencer_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AVG       = 3'd0,
        OP_DBL_SUM   = 3'd1,
        OP_HALFX_ADD = 3'd2,
        OP_SUB_HALFY = 3'd3,
        OP_NAND      = 3'd4,
        OP_NOT       = 3'd5,
        OP_NOR       = 3'd6,
        OP_XOR       = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } seq_state_e;

    // Command record is {chain, op, x, y}.
    function automatic int cmdWidth(input int n);
        return 1 + OP_W + 2 * n;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Small circular command FIFO with occupancy count, full/empty flags and a
// synchronous flush that discards every stored entry.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues queued ALU commands one at a time through registered operand ports,
// captures the widened result and hands it out over a valid/ready handshake.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_chain,
    input  logic [OP_W-1:0]  in_op,
    input  logic [N-1:0]     in_x,
    input  logic [N-1:0]     in_y,
    output logic [N-1:0]     alu_x,
    output logic [N-1:0]     alu_y,
    output logic [OP_W-1:0]  alu_c,
    input  logic [N+1:0]     alu_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N+1:0]     out_result,
    output logic             out_ovf,
    output logic [CNT_W-1:0] op_count,
    output logic             busy
);

    localparam int RW    = N + 2;
    localparam int CMD_W = cmdWidth(N);

    localparam logic signed [RW-1:0] RES_MAX = {3'b000, {(N-1){1'b1}}};
    localparam logic signed [RW-1:0] RES_MIN = {3'b111, {(N-1){1'b0}}};
    localparam logic [N-1:0]         SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]         SAT_MIN = {1'b1, {(N-1){1'b0}}};

    seq_state_e              state_q, state_d;
    logic [N-1:0]            alu_x_q, alu_x_d;
    logic [N-1:0]            alu_y_q, alu_y_d;
    logic [OP_W-1:0]         alu_c_q, alu_c_d;
    logic                    out_valid_q, out_valid_d;
    logic [RW-1:0]           out_result_q, out_result_d;
    logic                    out_ovf_q, out_ovf_d;
    logic [CNT_W-1:0]        op_count_q, op_count_d;
    logic signed [RW-1:0]    last_result_q, last_result_d;

    logic [CMD_W-1:0]        fifo_wdata;
    logic [CMD_W-1:0]        fifo_rdata;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;
    logic                    cmd_push;

    logic                    head_chain;
    logic [OP_W-1:0]         head_op;
    logic [N-1:0]            head_x;
    logic [N-1:0]            head_y;
    logic signed [RW-1:0]    alu_res;
    logic                    alu_ovf;

    function automatic logic [N-1:0] satN(input logic signed [RW-1:0] v);
        if (v > RES_MAX) begin
            return SAT_MAX;
        end
        if (v < RES_MIN) begin
            return SAT_MIN;
        end
        return v[N-1:0];
    endfunction

    assign in_ready   = !fifo_full;
    assign cmd_push   = in_valid && in_ready;
    assign fifo_wdata = {in_chain, in_op, in_x, in_y};
    assign {head_chain, head_op, head_x, head_y} = fifo_rdata;
    assign alu_res    = alu_o;
    assign alu_ovf    = (alu_res > RES_MAX) || (alu_res < RES_MIN);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (cmd_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Operand registers only move on a pop, so the ALU inputs never glitch.
    always_comb begin
        state_d       = state_q;
        alu_x_d       = alu_x_q;
        alu_y_d       = alu_y_q;
        alu_c_d       = alu_c_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_ovf_d     = out_ovf_q;
        op_count_d    = op_count_q;
        last_result_d = last_result_q;
        fifo_pop      = 1'b0;

        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        alu_c_d  = head_op;
                        alu_y_d  = head_y;
                        alu_x_d  = head_chain ? satN(last_result_q) : head_x;
                        state_d  = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    out_result_d  = alu_o;
                    out_ovf_d     = alu_ovf;
                    out_valid_d   = 1'b1;
                    last_result_d = alu_res;
                    state_d       = ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        op_count_d  = op_count_q + 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            alu_x_q       <= '0;
            alu_y_q       <= '0;
            alu_c_q       <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_ovf_q     <= 1'b0;
            op_count_q    <= '0;
            last_result_q <= '0;
        end else begin
            state_q       <= state_d;
            alu_x_q       <= alu_x_d;
            alu_y_q       <= alu_y_d;
            alu_c_q       <= alu_c_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_ovf_q     <= out_ovf_d;
            op_count_q    <= op_count_d;
            last_result_q <= last_result_d;
        end
    end

    assign alu_x      = alu_x_q;
    assign alu_y      = alu_y_q;
    assign alu_c      = alu_c_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_ovf    = out_ovf_q;
    assign op_count   = op_count_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: arithmetic ALU stand-in, queue-based
// reference model checked every cycle, plus directed hand-computed scenarios.
module tb_alu_op_sequencer;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int RW    = N + 2;
    localparam int VMAX  = (1 << (N - 1)) - 1;
    localparam int VMIN  = -(1 << (N - 1));

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_chain = 1'b0;
    logic [2:0]       in_op = '0;
    logic [N-1:0]     in_x = '0;
    logic [N-1:0]     in_y = '0;
    logic [N-1:0]     alu_x;
    logic [N-1:0]     alu_y;
    logic [2:0]       alu_c;
    logic [RW-1:0]    alu_o;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [RW-1:0]    out_result;
    logic             out_ovf;
    logic [CNT_W-1:0] op_count;
    logic             busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit chain;
        int op;
        int x;
        int y;
    } cmd_t;

    cmd_t mq[$];
    int   expX;
    int   expRes;
    int   expOvf;
    int   lastRes;
    int   mCount;
    bit   evaluated;
    bit   committed;
    int   aluWide;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .N     (N),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_chain   (in_chain),
        .in_op      (in_op),
        .in_x       (in_x),
        .in_y       (in_y),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_c      (alu_c),
        .alu_o      (alu_o),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .op_count   (op_count),
        .busy       (busy)
    );

    // Arithmetic meaning of the eight ALU functions on signed integers.
    function automatic int aluInt(input int op, input int x, input int y);
        case (op)
            0:       return (x + y) >>> 1;
            1:       return 2 * (x + y);
            2:       return (x >>> 1) + y;
            3:       return x - (y >>> 1);
            4:       return ~(x & y);
            5:       return ~x;
            6:       return ~(x | y);
            default: return x ^ y;
        endcase
    endfunction

    function automatic int satInt(input int v);
        if (v > VMAX) return VMAX;
        if (v < VMIN) return VMIN;
        return v;
    endfunction

    always_comb aluWide = aluInt(int'(alu_c), int'($signed(alu_x)), int'($signed(alu_y)));
    assign alu_o = aluWide[RW-1:0];

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: bound expired waiting for DUT", name);
    endtask

    task automatic applyStimulus(input bit ch, input int op, input int x, input int y);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (in_ready) begin
                in_chain = ch;
                in_op    = 3'(op);
                in_x     = N'(x);
                in_y     = N'(y);
                in_valid = 1'b1;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        failNow("push_timeout");
    endtask

    task automatic getResult(output int res, output int ovf, output int ax);
        int n;
        n   = 0;
        res = 0;
        ovf = 0;
        ax  = 0;
        while (!out_valid) begin
            if (n >= 30) begin
                failNow("result_timeout");
                return;
            end
            @(negedge clk);
            n++;
        end
        res = int'($signed(out_result));
        ovf = int'(out_ovf);
        ax  = int'($signed(alu_x));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r, o, a;
        int bpRes[5];
        int bpOvf[5];
        bpRes = '{3, -5, 4, -1, -32};
        bpOvf = '{0, 0, 0, 0, 1};

        fork
            // Reference model: tracks accepted commands and completed handshakes.
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    mq.delete();
                    evaluated = 1'b0;
                    committed = 1'b0;
                    lastRes   = 0;
                    mCount    = 0;
                end else begin
                    if (out_valid && evaluated && !committed) begin
                        lastRes   = expRes;
                        committed = 1'b1;
                    end
                    if (flush) begin
                        mq.delete();
                        evaluated = 1'b0;
                    end else begin
                        if (out_valid && out_ready) begin
                            if (mq.size() > 0) mq.delete(0);
                            evaluated = 1'b0;
                            mCount    = (mCount + 1) % (1 << CNT_W);
                        end
                        if (in_valid && in_ready) begin
                            mq.push_back('{in_chain, int'(in_op), int'($signed(in_x)), int'($signed(in_y))});
                        end
                    end
                    if (mq.size() > 0 && !evaluated) begin
                        expX      = mq[0].chain ? satInt(lastRes) : mq[0].x;
                        expRes    = aluInt(mq[0].op, expX, mq[0].y);
                        expOvf    = (expRes > VMAX || expRes < VMIN) ? 1 : 0;
                        evaluated = 1'b1;
                        committed = 1'b0;
                    end
                end
            end
            // Per-cycle comparison against the model.
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    checkOutput("mon_op_count", int'(op_count), mCount);
                    checkOutput("mon_busy", int'(busy), (mq.size() != 0) ? 1 : 0);
                    if (out_valid) begin
                        if (!evaluated) begin
                            failNow("mon_unexpected_valid");
                        end else begin
                            checkOutput("mon_result", int'($signed(out_result)), expRes);
                            checkOutput("mon_ovf", int'(out_ovf), expOvf);
                            checkOutput("mon_alu_x", int'($signed(alu_x)), expX);
                        end
                    end
                end
            end
        join_none

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_alu_x", int'(alu_x), 0);
        checkOutput("rst_alu_c", int'(alu_c), 0);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_op_count", int'(op_count), 0);
        checkOutput("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", int'(in_ready), 1);

        // Single op with latency check: avg(3,5) = 4
        applyStimulus(1'b0, 0, 3, 5);
        @(negedge clk);
        checkOutput("t1_valid_pop_cycle", int'(out_valid), 0);
        @(negedge clk);
        checkOutput("t1_valid_exec", int'(out_valid), 0);
        checkOutput("t1_alu_c", int'(alu_c), 0);
        checkOutput("t1_alu_x", int'(alu_x), 3);
        checkOutput("t1_alu_y", int'(alu_y), 5);
        @(negedge clk);
        checkOutput("t1_valid", int'(out_valid), 1);
        checkOutput("t1_result", int'($signed(out_result)), 4);
        checkOutput("t1_ovf", int'(out_ovf), 0);
        @(negedge clk);
        checkOutput("t1_valid_after", int'(out_valid), 0);
        checkOutput("t1_op_count", int'(op_count), 1);
        checkOutput("t1_busy", int'(busy), 0);

        // Overflow then chained op using the saturated result
        applyStimulus(1'b0, 1, 7, 7);
        applyStimulus(1'b1, 3, 0, 2);
        getResult(r, o, a);
        checkOutput("t2_dbl_result", r, 28);
        checkOutput("t2_dbl_ovf", o, 1);
        getResult(r, o, a);
        checkOutput("t2_chain_alu_x", a, 7);
        checkOutput("t2_chain_result", r, 6);
        checkOutput("t2_chain_ovf", o, 0);

        // Logic ops
        applyStimulus(1'b0, 5, 0, 0);
        getResult(r, o, a);
        checkOutput("t3_not_result", r, -1);
        checkOutput("t3_not_ovf", o, 0);
        applyStimulus(1'b0, 7, 5, 3);
        getResult(r, o, a);
        checkOutput("t3_xor_result", r, 6);
        checkOutput("t3_op_count", int'(op_count), 5);

        // Backpressure: five commands while the consumer stalls
        out_ready = 1'b0;
        applyStimulus(1'b0, 7, 1, 2);
        applyStimulus(1'b0, 0, -4, -6);
        applyStimulus(1'b0, 2, 6, 1);
        applyStimulus(1'b0, 6, 0, 0);
        applyStimulus(1'b0, 1, -8, -8);
        @(negedge clk);
        checkOutput("bp_in_ready_full", int'(in_ready), 0);
        checkOutput("bp_valid_held", int'(out_valid), 1);
        repeat (5) @(negedge clk);
        checkOutput("bp_result_stable", int'($signed(out_result)), 3);
        checkOutput("bp_in_ready_still", int'(in_ready), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            getResult(r, o, a);
            checkOutput("bp_result", r, bpRes[i]);
            checkOutput("bp_ovf", o, bpOvf[i]);
        end
        checkOutput("bp_op_count", int'(op_count), 10);

        // Flush while holding a result with two commands queued
        out_ready = 1'b0;
        applyStimulus(1'b0, 7, 1, 1);
        applyStimulus(1'b0, 0, 2, 2);
        applyStimulus(1'b0, 1, 3, 3);
        for (int n = 0; n < 30 && !out_valid; n++) @(negedge clk);
        checkOutput("fl_valid_before", int'(out_valid), 1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checkOutput("fl_valid", int'(out_valid), 0);
        checkOutput("fl_busy", int'(busy), 0);
        checkOutput("fl_in_ready", int'(in_ready), 1);
        checkOutput("fl_op_count", int'(op_count), 10);
        out_ready = 1'b1;
        applyStimulus(1'b0, 0, 2, 2);
        getResult(r, o, a);
        checkOutput("fl_next_result", r, 2);
        checkOutput("fl_next_count", int'(op_count), 11);

        // Asynchronous reset while the ALU is settling
        applyStimulus(1'b0, 1, 5, 6);
        @(negedge clk);
        @(negedge clk);
        checkOutput("ar_exec_alu_x", int'(alu_x), 5);
        checkOutput("ar_exec_valid", int'(out_valid), 0);
        rst_n = 1'b0;
        #1;
        checkOutput("ar_alu_x", int'(alu_x), 0);
        checkOutput("ar_alu_y", int'(alu_y), 0);
        checkOutput("ar_alu_c", int'(alu_c), 0);
        checkOutput("ar_out_valid", int'(out_valid), 0);
        checkOutput("ar_out_result", int'(out_result), 0);
        checkOutput("ar_out_ovf", int'(out_ovf), 0);
        checkOutput("ar_op_count", int'(op_count), 0);
        checkOutput("ar_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("ar_in_ready", int'(in_ready), 1);
        applyStimulus(1'b1, 2, 3, 1);
        getResult(r, o, a);
        checkOutput("ar_chain_alu_x", a, 0);
        checkOutput("ar_chain_result", r, 1);
        checkOutput("ar_chain_ovf", o, 0);
        checkOutput("ar_chain_count", int'(op_count), 1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
